// File: rtl/udp_port_splitter_if.sv
// UDP metadata/data stream bundle shared by the receive engine and the
// per-port application consumers. CH is the number of independent
// valid/ready lanes; the payload fields are shared across lanes.

`ifndef PORT_NUM_W
`define PORT_NUM_W 16
`endif

package udp_port_splitter_pkg;
    typedef struct packed {
        logic [31:0]            src_ip;
        logic [31:0]            dst_ip;
        logic [`PORT_NUM_W-1:0] src_port;
        logic [`PORT_NUM_W-1:0] dst_port;
        logic [15:0]            data_length;
    } udp_info;
endpackage

interface udp_port_splitter_if #(
    parameter int NOC_DATA_W     = 32,
    parameter int NOC_PADBYTES_W = 2,
    parameter int CH             = 1
);
    logic [CH-1:0]                  meta_val;
    udp_port_splitter_pkg::udp_info meta_info;
    logic [CH-1:0]                  meta_rdy;
    logic [CH-1:0]                  data_val;
    logic [NOC_DATA_W-1:0]          data;
    logic                           data_last;
    logic [NOC_PADBYTES_W-1:0]      data_padbytes;
    logic [CH-1:0]                  data_rdy;

    // Producer side of the stream
    modport master (
        output meta_val, meta_info, data_val, data, data_last, data_padbytes,
        input  meta_rdy, data_rdy
    );

    // Consumer side of the stream
    modport slave (
        input  meta_val, meta_info, data_val, data, data_last, data_padbytes,
        output meta_rdy, data_rdy
    );
endinterface

// File: rtl/udp_port_splitter.sv
// N-way UDP receive demultiplexer: steers each packet (one metadata flit plus
// its data beats) to the channel whose table port equals the packet's
// destination port. Unmatched packets are swallowed and counted.

`ifndef PORT_NUM_W
`define PORT_NUM_W 16
`endif

module udp_port_splitter #(
    parameter int NOC_DATA_W     = -1,
    parameter int NOC_PADBYTES   = NOC_DATA_W / 8,
    parameter int NOC_PADBYTES_W = $clog2(NOC_PADBYTES),
    parameter int NUM_DST        = 4,
    parameter logic [`PORT_NUM_W*NUM_DST-1:0] DST_PORTS = '0,
    parameter int DROP_CNT_W     = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    udp_port_splitter_if.slave     src,
    udp_port_splitter_if.master    dst,
    output logic [DROP_CNT_W-1:0]  drop_cnt
);
    localparam int SEL_W = (NUM_DST > 1) ? $clog2(NUM_DST) : 1;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] META_OUT  = 2'd1;
    localparam logic [1:0] DATA_PASS = 2'd2;
    localparam logic [1:0] DROP      = 2'd3;

    logic [1:0]                     state;
    udp_port_splitter_pkg::udp_info meta_reg;
    logic [SEL_W-1:0]               sel_reg;
    logic [SEL_W-1:0]               sel_nxt;
    logic                           hit;
    logic                           src_rdy;
    logic                           beat_hs;
    logic                           last_hs;
    logic [NUM_DST-1:0]             meta_val_vec;
    logic [NUM_DST-1:0]             data_val_vec;
    logic [NOC_DATA_W-1:0]          beat_data;
    logic [NOC_PADBYTES_W-1:0]      beat_pad;

    // Table lookup: scan downward so the lowest matching index is the one kept
    always_comb begin
        hit     = 1'b0;
        sel_nxt = '0;
        for (int i = NUM_DST - 1; i >= 0; i--) begin
            if (DST_PORTS[i*`PORT_NUM_W +: `PORT_NUM_W] == src.meta_info.dst_port) begin
                hit     = 1'b1;
                sel_nxt = SEL_W'(i);
            end
        end
    end

    // Upstream data ready: follows the selected consumer when passing, always set when dropping
    always_comb begin
        case (state)
            DATA_PASS: src_rdy = dst.data_rdy[sel_reg];
            DROP:      src_rdy = 1'b1;
            default:   src_rdy = 1'b0;
        endcase
    end

    assign beat_hs = src.data_val[0] & src_rdy;
    assign last_hs = beat_hs & src.data_last;

    // Per-channel valids: only the selected lane, and only in its own phase
    always_comb begin
        for (int i = 0; i < NUM_DST; i++) begin
            meta_val_vec[i] = (state == META_OUT) && (sel_reg == SEL_W'(i));
            data_val_vec[i] = (state == DATA_PASS) && (sel_reg == SEL_W'(i)) && src.data_val[0];
        end
    end

    assign src.meta_rdy[0] = (state == IDLE);
    assign src.data_rdy[0] = src_rdy;

    assign beat_data         = src.data;
    assign beat_pad          = src.data_padbytes;
    assign dst.meta_val      = meta_val_vec;
    assign dst.meta_info     = meta_reg;
    assign dst.data_val      = data_val_vec;
    assign dst.data          = beat_data;
    assign dst.data_last     = src.data_last;
    assign dst.data_padbytes = beat_pad;

    // Packet sequencing and drop counting; one packet in flight at a time
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            drop_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (src.meta_val[0]) begin
                        state <= hit ? META_OUT : DROP;
                    end
                end
                META_OUT: begin
                    if (dst.meta_rdy[sel_reg]) begin
                        state <= DATA_PASS;
                    end
                end
                DATA_PASS: begin
                    if (last_hs) begin
                        state <= IDLE;
                    end
                end
                DROP: begin
                    if (last_hs) begin
                        state    <= IDLE;
                        drop_cnt <= drop_cnt + DROP_CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Capture metadata and routing choice when a new packet is accepted
    always_ff @(posedge clk) begin
        if (state == IDLE && src.meta_val[0]) begin
            meta_reg <= src.meta_info;
            sel_reg  <= sel_nxt;
        end
    end
endmodule

// File: tb/tb_udp_port_splitter.sv
// Directed bench for udp_port_splitter. A second instance with a duplicated
// table entry shadows the same source stream with all consumers ready.

`timescale 1ns/1ps

module tb_udp_port_splitter;
    localparam int DW = 32;
    localparam int PW = 2;
    localparam int ND = 4;
    localparam logic [63:0] PORTS_A = {16'd400, 16'd300, 16'd200, 16'd100};
    localparam logic [63:0] PORTS_B = {16'd400, 16'd300, 16'd100, 16'd100};

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  drop_a;
    logic [31:0] drop_b;

    always #5 clk = ~clk;

    udp_port_splitter_if #(.NOC_DATA_W(DW), .NOC_PADBYTES_W(PW), .CH(1))  src_a ();
    udp_port_splitter_if #(.NOC_DATA_W(DW), .NOC_PADBYTES_W(PW), .CH(ND)) dst_a ();
    udp_port_splitter_if #(.NOC_DATA_W(DW), .NOC_PADBYTES_W(PW), .CH(1))  src_b ();
    udp_port_splitter_if #(.NOC_DATA_W(DW), .NOC_PADBYTES_W(PW), .CH(ND)) dst_b ();

    udp_port_splitter #(.NOC_DATA_W(DW), .NUM_DST(ND), .DST_PORTS(PORTS_A), .DROP_CNT_W(2)) u_dut (
        .clk(clk), .rst(rst), .src(src_a), .dst(dst_a), .drop_cnt(drop_a)
    );

    udp_port_splitter #(.NOC_DATA_W(DW), .NUM_DST(ND), .DST_PORTS(PORTS_B), .DROP_CNT_W(32)) u_dup (
        .clk(clk), .rst(rst), .src(src_b), .dst(dst_b), .drop_cnt(drop_b)
    );

    assign src_b.meta_val      = src_a.meta_val;
    assign src_b.meta_info     = src_a.meta_info;
    assign src_b.data_val      = src_a.data_val;
    assign src_b.data          = src_a.data;
    assign src_b.data_last     = src_a.data_last;
    assign src_b.data_padbytes = src_a.data_padbytes;
    assign dst_b.meta_rdy      = '1;
    assign dst_b.data_rdy      = '1;

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          acc_q[$];
    int          last_q[$];
    int          dmeta_q[$];
    logic [36:0] beat_q[$];
    int          multi = 0;
    int          dup_bad = 0;
    int          dup_ch0 = 0;
    logic        meta_hold;
    logic [15:0] next_port;
    logic        toggle_en;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Handshake monitor: values here are what the following rising edge samples
    always @(negedge clk) begin
        if (!rst) begin
            if (src_a.meta_val[0] && src_a.meta_rdy[0]) acc_q.push_back(cyc);
            if (src_a.data_val[0] && src_a.data_rdy[0] && src_a.data_last) last_q.push_back(cyc);
            for (int i = 0; i < ND; i++) begin
                if (dst_a.meta_val[i] && dst_a.meta_rdy[i]) dmeta_q.push_back(i);
                if (dst_a.data_val[i] && dst_a.data_rdy[i])
                    beat_q.push_back({i[1:0], dst_a.data_last, dst_a.data_padbytes, dst_a.data});
            end
            if ($countones(dst_a.data_val) > 1 || $countones(dst_a.meta_val) > 1) multi++;
            if (dst_b.data_val[3:1] != 3'b000 || dst_b.meta_val[3:1] != 3'b000) dup_bad++;
            if (dst_b.data_val[0]) dup_ch0++;
        end
    end

    task automatic clear_logs;
        acc_q.delete();
        last_q.delete();
        dmeta_q.delete();
        beat_q.delete();
        dup_bad = 0;
        dup_ch0 = 0;
    endtask

    task automatic drive_meta(input logic [15:0] port);
        int n;
        @(posedge clk); #1;
        src_a.meta_val  = 1'b1;
        src_a.meta_info = '{src_ip: 32'h0a000001, dst_ip: 32'h0a000002,
                            src_port: 16'd5000, dst_port: port, data_length: 16'd64};
        n = 0;
        @(negedge clk);
        while (!src_a.meta_rdy[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("meta_timeout", 0, 1);
    endtask

    task automatic send_beat(input logic [31:0] d, input logic last);
        int n;
        @(posedge clk); #1;
        if (toggle_en) dst_a.data_rdy[1] = ~dst_a.data_rdy[1];
        src_a.meta_val = meta_hold;
        if (meta_hold) src_a.meta_info.dst_port = next_port;
        src_a.data_val      = 1'b1;
        src_a.data          = d;
        src_a.data_last     = last;
        src_a.data_padbytes = d[1:0];
        n = 0;
        forever begin
            @(negedge clk);
            if (src_a.data_rdy[0] || n >= 100) break;
            @(posedge clk); #1;
            if (toggle_en) dst_a.data_rdy[1] = ~dst_a.data_rdy[1];
            n++;
        end
        if (n >= 100) chk("beat_timeout", 0, 1);
    endtask

    task automatic send_beats(input int n, input logic [31:0] base);
        for (int b = 0; b < n; b++) send_beat(base + 32'(b), (b == n - 1));
    endtask

    task automatic end_pkt;
        @(posedge clk); #1;
        src_a.data_val  = 1'b0;
        src_a.data_last = 1'b0;
        src_a.meta_val  = meta_hold;
    endtask

    task automatic check_beats(input string tag, input int ch, input int n, input logic [31:0] base);
        logic [36:0] e;
        logic [36:0] g;
        logic [31:0] d;
        logic [1:0]  c;
        c = ch[1:0];
        for (int b = 0; b < n; b++) begin
            d = base + 32'(b);
            e = {c, (b == n - 1), d[1:0], d};
            if (beat_q.size() == 0) begin
                chk($sformatf("%s_missing%0d", tag, b), 0, 1);
            end else begin
                g = beat_q.pop_front();
                chk($sformatf("%s_beat%0d", tag, b), 64'(g), 64'(e));
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        src_a.meta_val = 1'b0;
        src_a.meta_info = '0;
        src_a.data_val = 1'b0;
        src_a.data = '0;
        src_a.data_last = 1'b0;
        src_a.data_padbytes = '0;
        dst_a.meta_rdy = '1;
        dst_a.data_rdy = '1;
        meta_hold = 1'b0;
        next_port = '0;
        toggle_en = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_meta_rdy", src_a.meta_rdy, 1);
        chk("rst_data_rdy", src_a.data_rdy, 0);
        chk("rst_meta_val", dst_a.meta_val, 0);
        chk("rst_data_val", dst_a.data_val, 0);
        chk("rst_drop_cnt", drop_a, 0);

        // Matched packet to port 300, 3 beats, all consumers ready
        clear_logs();
        @(posedge clk); #1;
        src_a.data_val = 1'b1;
        src_a.data = 32'hdead0000;
        @(negedge clk);
        chk("idle_no_consume", src_a.data_rdy, 0);
        drive_meta(16'd300);
        @(negedge clk);
        chk("t1_meta_val", dst_a.meta_val, 4'b0100);
        chk("t1_meta_port", dst_a.meta_info.dst_port, 16'd300);
        chk("t1_metaout_no_consume", src_a.data_rdy, 0);
        chk("t1_metaout_meta_rdy", src_a.meta_rdy, 0);
        send_beats(3, 32'h00001000);
        end_pkt();
        @(negedge clk);
        chk("t1_idle_after", src_a.meta_rdy, 1);
        check_beats("t1", 2, 3, 32'h00001000);
        chk("t1_extra", beat_q.size(), 0);
        chk("t1_dmeta_n", dmeta_q.size(), 1);
        if (dmeta_q.size() > 0) chk("t1_dmeta_ch", dmeta_q[0], 2);
        if (acc_q.size() > 0 && last_q.size() > 0) chk("t1_occupancy", last_q[0] - acc_q[0], 4);
        else chk("t1_occupancy_logged", 0, 1);
        chk("t1_drop_cnt", drop_a, 0);

        // Unmatched port 555, 2 beats
        clear_logs();
        drive_meta(16'd555);
        @(negedge clk);
        chk("t2_drop_src_rdy", src_a.data_rdy, 1);
        chk("t2_drop_meta_val", dst_a.meta_val, 0);
        chk("t2_drop_cnt_before", drop_a, 0);
        send_beats(2, 32'h00002000);
        end_pkt();
        @(negedge clk);
        chk("t2_drop_cnt_after", drop_a, 1);
        chk("t2_no_beats", beat_q.size(), 0);
        chk("t2_no_meta", dmeta_q.size(), 0);

        // Backpressure on channel 1
        clear_logs();
        dst_a.meta_rdy = 4'b1101;
        drive_meta(16'd200);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            src_a.meta_val = 1'b0;
            src_a.meta_info.dst_port = 16'hbeef;
            @(negedge clk);
            chk($sformatf("t3_wait_val%0d", k), dst_a.meta_val, 4'b0010);
            chk($sformatf("t3_wait_port%0d", k), dst_a.meta_info.dst_port, 16'd200);
        end
        @(posedge clk); #1;
        dst_a.meta_rdy = 4'b1111;
        toggle_en = 1'b1;
        send_beats(4, 32'h00003000);
        end_pkt();
        toggle_en = 1'b0;
        dst_a.data_rdy = '1;
        @(negedge clk);
        check_beats("t3", 1, 4, 32'h00003000);
        chk("t3_extra", beat_q.size(), 0);
        chk("t3_dmeta_n", dmeta_q.size(), 1);
        if (dmeta_q.size() > 0) chk("t3_dmeta_ch", dmeta_q[0], 1);

        // Back-to-back: ports 100 then 400, metadata valid held high
        clear_logs();
        meta_hold = 1'b1;
        next_port = 16'd400;
        drive_meta(16'd100);
        send_beats(2, 32'h00004000);
        meta_hold = 1'b0;
        drive_meta(16'd400);
        send_beats(2, 32'h00005000);
        end_pkt();
        @(negedge clk);
        chk("t4_acc_n", acc_q.size(), 2);
        if (acc_q.size() > 1 && last_q.size() > 0) chk("t4_second_accept", acc_q[1] - last_q[0], 1);
        else chk("t4_second_accept_logged", 0, 1);
        check_beats("t4a", 0, 2, 32'h00004000);
        check_beats("t4b", 3, 2, 32'h00005000);
        chk("t4_extra", beat_q.size(), 0);
        chk("t4_dmeta_n", dmeta_q.size(), 2);
        if (dmeta_q.size() > 1) begin
            chk("t4_dmeta0", dmeta_q[0], 0);
            chk("t4_dmeta1", dmeta_q[1], 3);
        end

        // Four more drops: 5 total wraps a 2-bit counter to 1
        clear_logs();
        for (int k = 0; k < 4; k++) begin
            drive_meta(16'd600 + 16'(k));
            send_beats(2, 32'h00006000 + 32'(k * 16));
        end
        end_pkt();
        @(negedge clk);
        chk("t5_drop_wrap", drop_a, 1);
        chk("t5_last_n", last_q.size(), 4);
        for (int k = 0; k < 4 && k < last_q.size() && k < acc_q.size(); k++)
            chk($sformatf("t5_occupancy%0d", k), last_q[k] - acc_q[k], 2);
        chk("t5_no_beats", beat_q.size(), 0);

        // Reset during beat 2 of 4
        clear_logs();
        drive_meta(16'd300);
        send_beat(32'h00007000, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        src_a.data = 32'h00007001;
        src_a.data_padbytes = 2'd1;
        @(posedge clk); #1;
        rst = 1'b0;
        src_a.data_val = 1'b0;
        src_a.meta_val = 1'b0;
        @(negedge clk);
        chk("t6_data_val", dst_a.data_val, 0);
        chk("t6_meta_val", dst_a.meta_val, 0);
        chk("t6_idle", src_a.meta_rdy, 1);
        chk("t6_src_rdy", src_a.data_rdy, 0);
        chk("t6_drop_cnt", drop_a, 0);

        // Post-reset packet to port 100; the duplicate-table instance must use channel 0 only
        clear_logs();
        drive_meta(16'd100);
        @(negedge clk);
        chk("t7_meta_val", dst_a.meta_val, 4'b0001);
        chk("t7_dup_meta_val", dst_b.meta_val, 4'b0001);
        send_beats(2, 32'h00008000);
        end_pkt();
        @(negedge clk);
        check_beats("t7", 0, 2, 32'h00008000);
        chk("t7_extra", beat_q.size(), 0);
        chk("t7_dup_ch0_beats", dup_ch0, 2);
        chk("t7_dup_other", dup_bad, 0);
        chk("t7_dup_drop", drop_b, 0);
        chk("onehot_valids", multi, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
